// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch buffer sitting between instruction memory and the FD
// latch. It walks a sequential fetch PC, issues at most one imem read per cycle
// while buffer credit remains, captures each returned word together with the
// PC it was fetched from, and hands the oldest entry to decode through a
// valid/ready handshake. A redirect from execute (taken branch/jump) throws
// away everything buffered or in flight and restarts fetch at the target.
//
// Ports
//   clock         in   1            rising-edge clock
//   reset         in   1            synchronous, active-low reset
//   address_imem  out  32           imem read address (always the fetch PC)
//   imem_req      out  1            a read is issued this cycle
//   q_imem        in   32           imem data, valid one cycle after the read
//   redirect      in   1            flush and restart request from execute
//   redirect_pc   in   32           restart address, used when redirect=1
//   out_valid     out  1            head entry available to decode
//   out_ready     in   1            decode accepts the head entry this cycle
//   out_instr     out  32           head instruction, 0 (NOP) when not valid
//   out_pc        out  32           PC of the head instruction, 0 when not valid
//   count         out  log2(D)+1    current buffer occupancy
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              address_imem,
    output logic                     imem_req,
    input  logic [31:0]              q_imem,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);  // pointer width
    localparam int CW = PW + 1;         // occupancy width (holds 0..DEPTH)

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t          mem [DEPTH];
    logic [31:0]     fetch_pc;
    logic            inflight;
    logic [31:0]     inflight_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   occ;

    logic [CW:0]     credit_used;
    logic            has_credit;
    logic            push;
    logic            pop;
    entry_t          head;

    // ------------------------------------------------------------------
    // Issue credit
    // ------------------------------------------------------------------
    // Every outstanding read already owns a slot, so credit counts buffered
    // entries plus the one in flight. A pop in the same cycle is deliberately
    // not credited back: this keeps imem_req off the out_ready path and costs
    // at most one cycle of fetch bandwidth right after the buffer fills.
    assign credit_used = {1'b0, occ} + {{CW{1'b0}}, inflight};
    assign has_credit  = credit_used < (CW+1)'(DEPTH);

    assign imem_req     = reset & ~redirect & has_credit;
    assign address_imem = fetch_pc;

    // ------------------------------------------------------------------
    // Handshake to decode
    // ------------------------------------------------------------------
    // During a redirect the head is stale by definition, so it is hidden
    // immediately rather than waiting for the flush edge.
    assign head      = mem[rd_ptr];
    assign out_valid = (occ != '0) & ~redirect;
    assign out_instr = out_valid ? head.instr : 32'd0;
    assign out_pc    = out_valid ? head.pc    : 32'd0;
    assign count     = occ;

    // The word returning this cycle belongs to the read issued last cycle.
    // A redirect kills it; a reset discards it along with everything else.
    assign push = reset & inflight & ~redirect;
    assign pop  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Entry storage (no reset needed: occupancy gates visibility)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: q_imem, pc: inflight_pc};
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
        end else if (redirect) begin
            // Flush: the last redirect seen before the stream resumes wins.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (imem_req) begin
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd1;  // wraps 0xFFFFFFFF -> 0
            end else begin
                inflight <= 1'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            // Credit rules guarantee push never lands on a full buffer.
            occ <= occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. The stimulus process drives reset, redirect
// and out_ready, and on every restart point (reset or redirect) loads the
// scoreboard with the program-order PC stream expected from that point. A
// separate monitor process, sampling on the falling edge, pops the scoreboard
// on every accepted handshake and compares PC and instruction against the imem
// model; it also checks idle outputs are zero and occupancy stays bounded.
// Cycle-exact expectations (latency, credit stall, wrap) are checked inline.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] q_imem = 32'd0;

    logic [31:0] address_imem;
    logic        imem_req;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .imem_req     (imem_req),
        .q_imem       (q_imem),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .count        (count)
    );

    always #5 clock = ~clock;

    // Instruction memory model: distinct word per address, 1-cycle latency.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    always @(posedge clock) q_imem <= imem_f(address_imem);

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Load the scoreboard with the sequential stream starting at pc.
    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(pc + 32'(i));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc %h expected none", out_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("pop_pc", out_pc, e);
                    chk("pop_instr", out_instr, imem_f(e));
                end
            end else if (!out_valid) begin
                chk("idle_pc", out_pc, 32'd0);
                chk("idle_instr", out_instr, 32'd0);
            end
            total++;
            if (count > 3'd4) begin
                bad++;
                $display("FAIL count_bound: got %0d expected <=4", count);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset with out_ready high: nothing may be presented or popped.
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Test 1: streaming with out_ready=1. Current cycle is cycle 1.
        reset = 1'b1;
        restart(32'd0);
        #1;
        chk("t1_req_c1", 32'(imem_req), 32'd1);
        chk("t1_addr_c1", address_imem, 32'd0);
        for (int k = 2; k <= 20; k++) begin
            step();
            #1;
            chk("t1_addr", address_imem, 32'(k - 1));
            chk("t1_req", 32'(imem_req), 32'd1);
            if (k == 2) chk("t1_valid_c2", 32'(out_valid), 32'd0);
            if (k == 3) begin
                chk("t1_valid_c3", 32'(out_valid), 32'd1);
                chk("t1_pc_c3", out_pc, 32'd0);
            end
        end

        // Test 2: out_ready=0 from reset until full, then drain.
        reset = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        restart(32'd0);
        for (int k = 2; k <= 7; k++) step();
        #1;
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_addr_hold", address_imem, 32'd4);
        chk("t2_valid_full", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        #1;
        chk("t2_resume_addr", address_imem, 32'd4);
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_count_after_pop", 32'(count), 32'd3);
        for (int k = 0; k < 10; k++) step();

        // Test 3: redirect with 3 buffered entries and one read in flight.
        reset = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        restart(32'd0);
        for (int k = 2; k <= 5; k++) step();
        #1;
        chk("t3_count_pre", 32'(count), 32'd3);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        restart(32'h40);
        #1;
        chk("t3_req_redir", 32'(imem_req), 32'd0);
        chk("t3_valid_redir", 32'(out_valid), 32'd0);
        step();
        redirect = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_count_post", 32'(count), 32'd0);
        chk("t3_valid_post", 32'(out_valid), 32'd0);
        chk("t3_addr_post", address_imem, 32'h40);
        chk("t3_req_post", 32'(imem_req), 32'd1);
        step();
        #1;
        chk("t3_valid_t2", 32'(out_valid), 32'd0);
        step();
        #1;
        chk("t3_valid_t3", 32'(out_valid), 32'd1);
        chk("t3_pc_t3", out_pc, 32'h40);

        // Test 4: out_ready toggling every cycle (monitor checks order).
        for (int i = 0; i < 50; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end

        // Test 5: redirect to the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        restart(32'hFFFF_FFFF);
        step();
        redirect = 1'b0;
        #1;
        chk("t5_addr_top", address_imem, 32'hFFFF_FFFF);
        chk("t5_req_top", 32'(imem_req), 32'd1);
        step();
        #1;
        chk("t5_addr_wrap", address_imem, 32'd0);
        step();
        #1;
        chk("t5_pc_top", out_pc, 32'hFFFF_FFFF);
        step();
        #1;
        chk("t5_pc_wrap", out_pc, 32'd0);
        for (int k = 0; k < 16; k++) step();

        // Test 6: reset mid-stream with the buffer nearly full and a read
        // in flight; pre-reset PCs are ~0x14 onward, so stale data is
        // distinguishable from the restarted stream.
        out_ready = 1'b0;
        for (int n = 0; n < 20 && count != 3'd4; n++) step();
        #1;
        chk("t6_full_wait", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("t6_req_refill", 32'(imem_req), 32'd1);
        step();
        #1;
        chk("t6_count_pre", 32'(count), 32'd3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        restart(32'd0);
        #1;
        chk("t6_valid_post", 32'(out_valid), 32'd0);
        chk("t6_pc_post", out_pc, 32'd0);
        chk("t6_instr_post", out_instr, 32'd0);
        chk("t6_count_post", 32'(count), 32'd0);
        chk("t6_addr_post", address_imem, 32'd0);
        chk("t6_req_post", 32'(imem_req), 32'd1);
        step();
        #1;
        chk("t6_valid_c2", 32'(out_valid), 32'd0);
        step();
        #1;
        chk("t6_valid_c3", 32'(out_valid), 32'd1);
        chk("t6_pc_c3", out_pc, 32'd0);
        for (int k = 0; k < 10; k++) step();

        out_ready = 1'b0;
        step();
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
